// File: rtl/imu_spi_reader.sv
// Periodic SPI burst reader for a six-axis IMU: reads 12 bytes starting at StartAddr
// and presents each axis as a 10-bit offset-binary sample with a ReadDone strobe.
module imu_spi_reader #(
  parameter int         ClkDiv        = 4,
  parameter int         SamplePeriod  = 746269,
  parameter logic [6:0] StartAddr     = 7'h3B,
  parameter int         ReadDonePulse = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  output logic       SpiCsN,
  output logic       SpiSclk,
  output logic       SpiMosi,
  input  logic       SpiMiso,
  output logic [9:0] AccelX,
  output logic [9:0] AccelY,
  output logic [9:0] AccelZ,
  output logic [9:0] GyroX,
  output logic [9:0] GyroY,
  output logic [9:0] GyroZ,
  output logic       ReadDone,
  output logic       Busy,
  output logic       Overrun
);

  localparam int         NumBits  = 104;
  localparam int         TickW    = $clog2(SamplePeriod + 1);
  localparam int         CntMax   = (ClkDiv > ReadDonePulse) ? ClkDiv : ReadDonePulse;
  localparam int         CntW     = $clog2(CntMax + 1);
  localparam logic [7:0] AddrByte = {1'b1, StartAddr};

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} stateT;

  stateT             state, stateNext;
  logic [TickW-1:0]  tickCnt;
  logic [CntW-1:0]   phaseCnt;
  logic [6:0]        bitIdx;
  logic [7:0]        txReg;
  logic [95:0]       rxReg;
  logic              tick, divEnd, pulseEnd, lastBit;

  function automatic logic [9:0] toOffsetBinary(input logic [15:0] raw);
    return {~raw[15], raw[14:6]};
  endfunction

  assign tick     = (tickCnt == TickW'(SamplePeriod - 1));
  assign divEnd   = (phaseCnt == CntW'(ClkDiv - 1));
  assign pulseEnd = (phaseCnt == CntW'(ReadDonePulse - 1));
  assign lastBit  = (bitIdx == 7'(NumBits - 1));
  assign Busy     = (state != IDLE);

  // NOTE: every variable assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (tick && Enable)                 stateNext = CS_SETUP;
      CS_SETUP: if (divEnd)                         stateNext = SHIFT;
      SHIFT:    if (divEnd && !SpiSclk && lastBit)  stateNext = CS_HOLD;
      CS_HOLD:  if (divEnd)                         stateNext = DONE;
      DONE:     if (pulseEnd)                       stateNext = IDLE;
      default:                                      stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      phaseCnt <= '0;
      SpiCsN   <= 1'b1;
      SpiSclk  <= 1'b1;
      SpiMosi  <= 1'b0;
      AccelX   <= '0;
      AccelY   <= '0;
      AccelZ   <= '0;
      GyroX    <= '0;
      GyroY    <= '0;
      GyroZ    <= '0;
      ReadDone <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      state   <= stateNext;
      tickCnt <= tick ? '0 : tickCnt + TickW'(1);
      if (tick && Busy) Overrun <= 1'b1;

      // One counter times every phase; SHIFT restarts it at each SCLK half-period.
      if (state == IDLE || stateNext != state || (state == SHIFT && divEnd))
        phaseCnt <= '0;
      else
        phaseCnt <= phaseCnt + CntW'(1);

      case (state)
        IDLE: if (stateNext == CS_SETUP) SpiCsN <= 1'b0;
        CS_SETUP: if (divEnd) begin
          SpiSclk <= 1'b0;
          SpiMosi <= AddrByte[7];
        end
        SHIFT: if (divEnd) begin
          if (!SpiSclk) begin
            SpiSclk <= 1'b1;
          end else begin
            SpiSclk <= 1'b0;
            SpiMosi <= txReg[7];
          end
        end
        CS_HOLD: if (divEnd) begin
          SpiCsN   <= 1'b1;
          SpiMosi  <= 1'b0;
          AccelX   <= toOffsetBinary(rxReg[95:80]);
          AccelY   <= toOffsetBinary(rxReg[79:64]);
          AccelZ   <= toOffsetBinary(rxReg[63:48]);
          GyroX    <= toOffsetBinary(rxReg[47:32]);
          GyroY    <= toOffsetBinary(rxReg[31:16]);
          GyroZ    <= toOffsetBinary(rxReg[15:0]);
          ReadDone <= 1'b1;
        end
        DONE: if (pulseEnd) ReadDone <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: the shift registers carry no reset; they are reloaded or fully overwritten
  // before any value in them reaches an output. The address byte shifts out of
  // the top of rxReg, leaving the 96 data bits.
  always_ff @(posedge Clock) begin
    if (state == CS_SETUP && divEnd) begin
      txReg  <= {AddrByte[6:0], 1'b0};
      bitIdx <= '0;
    end else if (state == SHIFT && divEnd) begin
      if (!SpiSclk) begin
        rxReg <= {rxReg[94:0], SpiMiso};
      end else begin
        txReg  <= {txReg[6:0], 1'b0};
        bitIdx <= bitIdx + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_imu_spi_reader.sv
// Bench for imu_spi_reader: three lanes (ClkDiv 4 / 4 / 1, SamplePeriod 1000 / 500 / 1000),
// each with an SPI sensor model and a timing-formula reference model.
module tb_imu_spi_reader;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] en;
  int         checks = 0;
  int         errors = 0;
  int         k = 0;

  localparam logic [95:0] Golden   = {16'h0000, 16'h7FFF, 16'h8000, 16'hFFC0, 16'h0040, 16'h1234};
  localparam logic [7:0]  AddrByte = 8'hBB;
  localparam logic [65:0] ResetVec = {2'b11, 64'd0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Offset binary = floor(signed value / 64) + 512.
  function automatic logic [9:0] toSample(input logic [15:0] raw);
    int v;
    v = int'($signed(raw));
    return 10'((v >>> 6) + 512);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int D      = (g == 2) ? 1 : 4;
    localparam int SP     = (g == 1) ? 500 : 1000;
    localparam int P      = 4;
    localparam int Xfer   = 209 * D;
    localparam int L      = Xfer + P;
    localparam int ExpLat = (g == 2) ? 209 : 836;

    logic        csN, sclk, mosi, miso, readDone, busy, overrun;
    logic [9:0]  aX, aY, aZ, gX, gY, gZ;
    logic [65:0] outs;
    logic        rstS, enS;

    assign outs = {csN, sclk, mosi, readDone, busy, overrun, aX, aY, aZ, gX, gY, gZ};

    imu_spi_reader #(
      .ClkDiv(D), .SamplePeriod(SP), .StartAddr(7'h3B), .ReadDonePulse(P)
    ) dut (
      .Clock(clk), .Reset(rst[g]), .Enable(en[g]),
      .SpiCsN(csN), .SpiSclk(sclk), .SpiMosi(mosi), .SpiMiso(miso),
      .AccelX(aX), .AccelY(aY), .AccelZ(aZ), .GyroX(gX), .GyroY(gY), .GyroZ(gZ),
      .ReadDone(readDone), .Busy(busy), .Overrun(overrun)
    );

    always @(posedge clk) begin
      rstS <= rst[g];
      enS  <= en[g];
    end

    // Sensor: mode 3, drives MISO on each SCLK fall, watches MOSI on each rise.
    logic [95:0]  frame = '0;
    logic [103:0] txFrame = '0;
    logic [7:0]   mosiByte = '0;
    bit           useGolden = 1'b1;
    int           fallCnt = 0;
    int           riseCnt = 0;

    initial miso = 1'b0;

    always @(negedge csN) begin
      frame     = useGolden ? Golden : {$urandom, $urandom, $urandom};
      useGolden = 1'b0;
      txFrame   = {8'($urandom), frame};
      fallCnt   = 0;
      riseCnt   = 0;
      mosiByte  = '0;
    end

    always @(negedge sclk) begin
      if (csN === 1'b0) begin
        if (fallCnt < 104) miso = txFrame[103 - fallCnt];
        fallCnt++;
      end
    end

    always @(posedge sclk) begin
      if (csN === 1'b0) begin
        if (riseCnt < 8) mosiByte = {mosiByte[6:0], mosi};
        riseCnt++;
      end
    end

    always @(posedge csN) begin
      if (rst[g] === 1'b0) begin
        check($sformatf("lane%0d sclk falls", g), 66'(fallCnt), 66'(104));
        check($sformatf("lane%0d mosi byte", g), 66'(mosiByte), 66'(AddrByte));
      end
    end

    // Reference model: tracks only tick schedule and transaction start; every
    // output follows from the offset r = edges since SpiCsN fell.
    int         e = 0, tc = 0, tStart = 0, cyc = 0, fallCyc = 0, riseCyc = 0;
    bit         act = 1'b0, ovr = 1'b0, valid = 1'b0, prevCsN = 1'b1, prevRd = 1'b0;
    bit         firstDone = 1'b1;
    logic [9:0] ax [6];

    always @(negedge clk) begin : model
      int          r, kb;
      bit          inT, busyPre;
      logic        expCsN, expSclk, expMosi;
      logic [65:0] want;
      cyc++;
      if (rstS === 1'b1) begin
        e = 0; tc = 0; act = 1'b0; ovr = 1'b0; valid = 1'b1;
        for (int i = 0; i < 6; i++) ax[i] = '0;
      end else if (valid) begin
        e++;
        busyPre = act && (e - 1 - tStart) < L;
        if (tc == SP - 1) begin
          if (busyPre) ovr = 1'b1;
          else if (enS) begin act = 1'b1; tStart = e; end
        end
        tc = (tc + 1) % SP;
        if (act && e - tStart == Xfer)
          for (int i = 0; i < 6; i++) ax[i] = toSample(frame[95 - 16*i -: 16]);
      end
      if (valid) begin
        r       = act ? e - tStart : L;
        inT     = r < L;
        expCsN  = !(inT && r < Xfer);
        expSclk = 1'b1;
        expMosi = 1'b0;
        if (inT && r >= D && r < Xfer) begin
          expSclk = ((r - D) % (2 * D)) >= D;
          kb = (r - D) / (2 * D);
          if (kb < 8) expMosi = AddrByte[7 - kb];
        end
        want = {expCsN, expSclk, expMosi, inT && r >= Xfer, inT, ovr,
                ax[0], ax[1], ax[2], ax[3], ax[4], ax[5]};
        check($sformatf("lane%0d cycle %0d", g, e), outs, want);

        if (prevCsN && !csN) fallCyc = cyc;
        if (!prevRd && readDone) begin
          riseCyc = cyc;
          check($sformatf("lane%0d csn-to-done", g), 66'(cyc - fallCyc), 66'(ExpLat));
          if (firstDone) begin
            firstDone = 1'b0;
            check($sformatf("lane%0d golden ax", g), 66'(aX), 66'(512));
            check($sformatf("lane%0d golden ay", g), 66'(aY), 66'(1023));
            check($sformatf("lane%0d golden az", g), 66'(aZ), 66'(0));
            check($sformatf("lane%0d golden gx", g), 66'(gX), 66'(511));
            check($sformatf("lane%0d golden gy", g), 66'(gY), 66'(513));
            check($sformatf("lane%0d golden gz", g), 66'(gZ), 66'(584));
          end
        end
        if (prevRd && !readDone)
          check($sformatf("lane%0d done width", g), 66'(cyc - riseCyc), 66'(P));
        prevCsN = csN;
        prevRd  = readDone;
      end
    end
  end

  task automatic stepTo(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    rst = '1;
    en  = '1;
    repeat (3) @(negedge clk);
    rst = '0;
    check("reset vec lane0", lane[0].outs, ResetVec);

    stepTo(499);  check("lane1 csn pre tick",  66'(lane[1].csN), 66'(1));
    stepTo(500);  check("lane1 csn start",     66'(lane[1].csN), 66'(0));
    stepTo(999);  check("idle vec lane0",      lane[0].outs, ResetVec);
                  check("idle vec lane2",      lane[2].outs, ResetVec);
    stepTo(1000); check("lane0 csn start",     66'(lane[0].csN), 66'(0));
                  check("lane2 csn start",     66'(lane[2].csN), 66'(0));
    stepTo(1100); check("lane1 overrun set",   66'(lane[1].overrun), 66'(1));
                  check("lane0 no overrun",    66'(lane[0].overrun), 66'(0));
    stepTo(1499); check("lane1 csn skipped",   66'(lane[1].csN), 66'(1));
    stepTo(1500); check("lane1 csn restart",   66'(lane[1].csN), 66'(0));
                  check("lane1 overrun stays", 66'(lane[1].overrun), 66'(1));

    // Reset lane0 while bit 50 is on the wire.
    stepTo(2404); check("lane0 bit50 low",     66'(lane[0].sclk), 66'(0));
    rst[0] = 1'b1;
    stepTo(2405); check("lane0 mid reset vec", lane[0].outs, ResetVec);
    rst[0] = 1'b0;

    stepTo(4300); en[0] = 1'b0;
    stepTo(4406); check("lane0 tick dropped",  66'(lane[0].csN), 66'(1));
                  check("lane0 busy dropped",  66'(lane[0].busy), 66'(0));
                  check("lane0 ovr dropped",   66'(lane[0].overrun), 66'(0));
    stepTo(4500); en[0] = 1'b1;
    stepTo(5500); en[0] = 1'b0;
    stepTo(6240); check("lane0 done early",    66'(lane[0].readDone), 66'(0));
    stepTo(6241); check("lane0 done after en", 66'(lane[0].readDone), 66'(1));
    stepTo(6245); check("lane0 done fall",     66'(lane[0].readDone), 66'(0));
                  check("lane0 busy fall",     66'(lane[0].busy), 66'(0));
    stepTo(6300); en[0] = 1'b1;
    stepTo(7000); check("lane0 next xfer",     66'(lane[0].csN), 66'(0));
                  check("lane2 no overrun",    66'(lane[2].overrun), 66'(0));
    stepTo(7300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
